// File: rtl/fc_pkg.sv
// Shared constants and arithmetic helpers for the FC and conv MAC engines.
// Helpers work on 64-bit signed values; callers pass the target width.
package fc_pkg;

    localparam int DEF_LANES    = 20;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_WEIGHT_W = 4;
    localparam int DEF_ACC_W    = 24;
    localparam int DEF_BIAS_W   = 16;
    localparam int DEF_OUT_W    = 8;
    localparam int DEF_CNT_W    = 8;

    function automatic logic signed [63:0] sat_w(
        input logic signed [63:0] x,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            sat_w = hi;
        end else if (x < lo) begin
            sat_w = lo;
        end else begin
            sat_w = x;
        end
    endfunction

    function automatic logic signed [63:0] sext(
        input logic [63:0] x,
        input int          w
    );
        sext = $signed(x << (64 - w)) >>> (64 - w);
    endfunction

endpackage

// File: rtl/fc_requant.sv
// Round-half-up arithmetic shift, saturate to OUT_W, optional ReLU.
// Purely combinational; shared by the FC and conv output stages.
module fc_requant
    import fc_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic signed [ACC_W-1:0] raw,
    input  logic        [4:0]       shift,
    input  logic                    relu,
    output logic signed [OUT_W-1:0] result
);

    // Headroom so the rounding constant for shift=31 never truncates.
    localparam int RW = ACC_W + 33;

    logic signed [RW-1:0] wide;
    logic signed [RW-1:0] rnd;
    logic signed [RW-1:0] shifted;
    logic signed [63:0]   clamped;

    always_comb begin
        wide    = {{33{raw[ACC_W-1]}}, raw};
        rnd     = {{(RW-1){1'b0}}, (shift != 5'd0)} << (shift - 5'd1);
        shifted = (wide + rnd) >>> shift;
        clamped = sat_w(64'(shifted), OUT_W);
        if (relu && clamped < 0) begin
            clamped = '0;
        end
        result = OUT_W'(clamped);
    end

endmodule

// File: rtl/fc_mac_engine.sv
// Streaming fully-connected dot-product engine: LANES MACs per beat,
// saturating accumulation over a configurable chunk count, requantised output.
module fc_mac_engine
    import fc_pkg::*;
#(
    parameter int LANES    = DEF_LANES,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int WEIGHT_W = DEF_WEIGHT_W,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int BIAS_W   = DEF_BIAS_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      srstn,
    input  logic [CNT_W-1:0]          cfg_num_chunks,
    input  logic [4:0]                cfg_shift,
    input  logic                      cfg_relu,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_data,
    input  logic [LANES*WEIGHT_W-1:0] in_weight,
    input  logic [BIAS_W-1:0]         in_bias,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic [ACC_W-1:0]          out_raw,
    output logic                      out_ovf,
    output logic                      busy
);

    localparam int PROD_W = DATA_W + WEIGHT_W;
    localparam int SUM_W  = PROD_W + $clog2(LANES) + 1;

    logic             advance;
    logic             accept;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] num_lat;
    logic [CNT_W-1:0] num_eff;
    logic [4:0]       shift_lat;
    logic             relu_lat;
    logic             first;
    logic             last;

    logic                      s1_valid;
    logic [LANES*DATA_W-1:0]   s1_data;
    logic [LANES*WEIGHT_W-1:0] s1_weight;
    logic [BIAS_W-1:0]         s1_bias;
    logic                      s1_first;
    logic                      s1_last;
    logic [4:0]                s1_shift;
    logic                      s1_relu;

    logic [ACC_W-1:0]   acc;
    logic               ovf;
    logic signed [SUM_W-1:0] sum;
    logic signed [PROD_W-1:0] prod;
    logic signed [63:0] total;
    logic [ACC_W-1:0]   acc_next;
    logic               ovf_next;
    logic [4:0]         out_shift;
    logic               out_relu;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance;
    assign first    = (cnt == '0);
    assign busy     = (cnt != '0) || s1_valid || out_valid;

    // Configuration is taken live on the first beat, latched afterwards.
    always_comb begin
        num_eff = num_lat;
        if (first) begin
            num_eff = (cfg_num_chunks == '0) ? CNT_W'(1) : cfg_num_chunks;
        end
        last = (cnt == num_eff - CNT_W'(1));
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            cnt       <= '0;
            num_lat   <= '0;
            shift_lat <= '0;
            relu_lat  <= 1'b0;
        end else if (accept) begin
            cnt <= last ? '0 : cnt + CNT_W'(1);
            if (first) begin
                num_lat   <= num_eff;
                shift_lat <= cfg_shift;
                relu_lat  <= cfg_relu;
            end
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_weight <= '0;
            s1_bias   <= '0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s1_shift  <= '0;
            s1_relu   <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data   <= in_data;
                s1_weight <= in_weight;
                s1_bias   <= in_bias;
                s1_first  <= first;
                s1_last   <= last;
                s1_shift  <= first ? cfg_shift : shift_lat;
                s1_relu   <= first ? cfg_relu : relu_lat;
            end
        end
    end

    // Lane 0 sits in the most significant slice.
    always_comb begin
        sum  = '0;
        prod = '0;
        for (int i = 0; i < LANES; i++) begin
            prod = $signed(s1_data[(LANES-1-i)*DATA_W +: DATA_W])
                 * $signed(s1_weight[(LANES-1-i)*WEIGHT_W +: WEIGHT_W]);
            sum  = sum + {{(SUM_W-PROD_W){prod[PROD_W-1]}}, prod};
        end
        total = (s1_first ? sext(64'(s1_bias), BIAS_W) : sext(64'(acc), ACC_W))
              + sext(64'(sum), SUM_W);
        acc_next = ACC_W'(sat_w(total, ACC_W));
        ovf_next = (!s1_first && ovf) || (sat_w(total, ACC_W) != total);
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            acc       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_raw   <= '0;
            out_ovf   <= 1'b0;
            out_shift <= '0;
            out_relu  <= 1'b0;
        end else if (advance) begin
            if (s1_valid) begin
                acc <= acc_next;
                ovf <= ovf_next;
            end
            if (s1_valid && s1_last) begin
                out_valid <= 1'b1;
                out_raw   <= acc_next;
                out_ovf   <= ovf_next;
                out_shift <= s1_shift;
                out_relu  <= s1_relu;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    fc_requant #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_requant (
        .raw    (out_raw),
        .shift  (out_shift),
        .relu   (out_relu),
        .result (out_data)
    );

endmodule

// File: doc/fc_mac_engine.md
Name: fc_mac_engine

Overview:
Parametrised, streaming fully-connected dot-product engine.
- Accepts one chunk of LANES activations plus LANES weights per beat.
- Accumulates a configurable number of chunks per output neuron on top of a per-neuron bias.
- Emits a requantised, optionally ReLU'd result through a valid/ready output port.
- Drops in wherever the FC layers need a neuron result, driven by the SRAM read controller. Replaces the external accumulate-reset pulse with an internal chunk counter and handshakes.

Parameters:
- LANES, 20, MAC lanes per beat.
- DATA_W, 8, signed activation width.
- WEIGHT_W, 4, signed weight width.
- ACC_W, 24, signed accumulator width (saturating).
- BIAS_W, 16, signed bias width.
- OUT_W, 8, signed requantised output width.
- CNT_W, 8, width of chunk-count configuration.

Ports:
- clk  in  1  clock, rising edge.
- srstn  in  1  reset, asynchronous, active-low.
- cfg_num_chunks  in  CNT_W  chunks per neuron. 0 is treated as 1.
- cfg_shift  in  5  arithmetic right shift for requantisation.
- cfg_relu  in  1  1 = clamp negative outputs to 0.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- in_data  in  LANES*DATA_W  activations. Lane 0 in the MS slice.
- in_weight  in  LANES*WEIGHT_W  weights. Lane 0 in the MS slice.
- in_bias  in  BIAS_W  neuron bias. Sampled on the first beat of each neuron only.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_data  out  OUT_W  requantised result.
- out_raw  out  ACC_W  full accumulator value before requantisation.
- out_ovf  out  1  accumulator saturated at least once during this neuron.
- busy  out  1  neuron partially accumulated, or pipeline or output holding data.

Behaviour:
- Reset (async, srstn low):
  - All registers cleared; takes effect immediately, independent of clk.
  - out_valid=0, out_data=0, out_raw=0, out_ovf=0, busy=0, chunk counter=0.
  - in_ready=1 from the first clk edge after release.
  - A neuron in flight is discarded. The next accepted beat is a first beat.
- Global advance: advance = !out_valid | out_ready. in_ready = advance.
  - All pipeline registers update only when advance=1.
  - out_valid/out_data/out_raw/out_ovf hold stable while out_valid & !out_ready.
- Chunk counter:
  - Increments on each accepted beat.
  - first = (cnt==0); last = (cnt==max(cfg_num_chunks,1)-1). cnt returns to 0 after the last beat.
  - cfg_num_chunks, cfg_shift and cfg_relu are latched on the first beat and held for the whole neuron. Mid-neuron changes are ignored.
- Stage 1 (S1): on acceptance, register data, weights, bias, first, last, shift and relu. S1 valid clears when advance=1 with no beat accepted.
- Stage 2 (accumulate), when S1 valid & advance:
  - Form all LANES signed products (DATA_W+WEIGHT_W bits each) and sum them sign-extended at full width.
  - base = first ? sign_ext(bias) : acc.
  - acc <= sat_ACC_W(base + sum).
  - ovf <= (first ? 0 : ovf) | saturated.
  - If last: load the output register and set out_valid.
- Latency: last beat accepted in cycle t → out_valid=1 in cycle t+2. Throughput is 1 beat/cycle when out_ready=1.
- Simultaneous events:
  - A result being consumed while a new last beat finishes in the same cycle reloads the output register with no bubble.
  - A first beat of neuron N+1 may be in S1 while neuron N is still in the output register.
- Requant (out_data), with r = out_raw:
  - If shift>0, r' = (r + 2^(shift-1)) >>> shift (round half up); otherwise r' = r.
  - Saturate r' to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - If relu and result<0, result = 0.
  - out_raw is never clamped by ReLU.
- Accumulator:
  - Saturates at ±ACC_W bounds. It never wraps.
  - out_ovf reflects the neuron just emitted.

Decomposition:
- Package fc_pkg: default LANES/DATA_W/WEIGHT_W/ACC_W/OUT_W constants, and saturate and sign-extend functions shared with the conv engines.
- Sub-module fc_requant (combinational round/shift/saturate/ReLU, parametrised by ACC_W and OUT_W), reused by other output stages.

Test Plan:
1. All lanes data=1, weight=1, chunks=1, bias=0, shift=0 → out_raw=20, out_data=20, out_valid exactly 2 cycles after acceptance.
2. All lanes data=-128, weight=-8, chunks=3, bias=0, shift=8 → out_raw=61440; 61568>>>8=240 saturates to out_data=127; out_ovf=0.
3. Bias=-100, data=1, weight=-1, chunks=1, relu=1 → out_raw=-120, out_data=0. Same with relu=0 → out_data=-120 saturates to -120 (in range).
4. Rounding: raw=6, shift=2 → 2; raw=-6, shift=2 → -1; cfg_num_chunks=0 behaves as 1.
5. Backpressure: stream 2 neurons (chunks=2) while out_ready=0 for 6 cycles → in_ready drops, first result holds stable, both results emitted in order with correct values, no beat lost.
6. srstn asserted asynchronously mid-clock with cnt=1 → out_valid and busy fall immediately. After release, a 1-chunk neuron with bias=5 and zero data gives out_raw=5 (no stale partial sum).
